// File: rtl/reg_sync_mp.sv
// Multi-port register file: NUM_REGS general registers plus pc and cspr, lowest-index write port wins.
// Latency: writes commit at the next rising edge; read data is registered and valid one edge after the request.
// Backpressure: none; every write, read, pc and cspr request is accepted on every edge and nothing stalls.
module reg_sync_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16,
    parameter int NUM_WR   = 4,
    parameter int NUM_RD   = 4,
    parameter int BYPASS   = 1,
    parameter int PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_WR-1:0]          write_enable,
    input  logic [NUM_WR*ADDR_W-1:0]   write_address,
    input  logic [NUM_WR*DATA_W-1:0]   write_data,
    input  logic [NUM_RD-1:0]          read_enable,
    input  logic [NUM_RD*ADDR_W-1:0]   in_address,
    output logic [NUM_RD*DATA_W-1:0]   out_data,
    input  logic                       pc_write,
    input  logic [DATA_W-1:0]          pc_update,
    input  logic                       pc_inc,
    output logic [DATA_W-1:0]          pc,
    input  logic                       cspr_write,
    input  logic [DATA_W-1:0]          cspr_update,
    output logic [DATA_W-1:0]          cspr,
    output logic [NUM_WR-1:0]          wr_conflict
);

    logic [DATA_W-1:0]        regs_q [NUM_REGS];
    logic [DATA_W-1:0]        regs_d [NUM_REGS];
    logic [NUM_RD*DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0]        pc_q, pc_d;
    logic [DATA_W-1:0]        cspr_q, cspr_d;
    logic [NUM_WR-1:0]        wr_conflict_q, wr_conflict_d;
    logic [NUM_WR-1:0]        wr_vld;

    // Qualify each write port: enabled and addressing an implemented register.
    always_comb begin
        wr_vld = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (write_enable[i] && (write_address[i*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    wr_vld[i] = 1'b1;
                end
            end
        end
    end

    // A port loses when any lower-index valid port targets the same address.
    always_comb begin
        wr_conflict_d = '0;
        for (int i = 1; i < NUM_WR; i++) begin
            for (int k = 0; k < i; k++) begin
                if (wr_vld[i] && wr_vld[k] &&
                    (write_address[i*ADDR_W +: ADDR_W] == write_address[k*ADDR_W +: ADDR_W])) begin
                    wr_conflict_d[i] = 1'b1;
                end
            end
        end
    end

    // Next register contents; ports applied high to low so the lowest index lands last and wins.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = regs_q[r];
            for (int i = NUM_WR - 1; i >= 0; i--) begin
                if (wr_vld[i] && (write_address[i*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    regs_d[r] = write_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Read data: bypass variant sees this edge's winning write, otherwise the stored value.
    always_comb begin
        logic [DATA_W-1:0] rd_val;
        rd_val     = '0;
        out_data_d = out_data_q;
        for (int j = 0; j < NUM_RD; j++) begin
            if (read_enable[j]) begin
                rd_val = '0;
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (in_address[j*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                        rd_val = (BYPASS != 0) ? regs_d[r] : regs_q[r];
                    end
                end
                out_data_d[j*DATA_W +: DATA_W] = rd_val;
            end
        end
    end

    // Program counter: explicit load beats increment; increment wraps modulo 2^DATA_W.
    always_comb begin
        pc_d = pc_q;
        if (pc_write) begin
            pc_d = pc_update;
        end else if (pc_inc) begin
            pc_d = pc_q + DATA_W'(PC_STEP);
        end
    end

    // Status register is a plain loadable register; flags are computed elsewhere.
    always_comb begin
        cspr_d = cspr_q;
        if (cspr_write) begin
            cspr_d = cspr_update;
        end
    end

    // State update; reset wins over every request presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            out_data_q    <= '0;
            pc_q          <= '0;
            cspr_q        <= '0;
            wr_conflict_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            out_data_q    <= out_data_d;
            pc_q          <= pc_d;
            cspr_q        <= cspr_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign out_data    = out_data_q;
    assign pc          = pc_q;
    assign cspr        = cspr_q;
    assign wr_conflict = wr_conflict_q;

endmodule
